pulse_sync_ctrl: RTL and testbench

//  Parametrised pulse-width synchroniser and frequency tracker for the RFID Rx decoder.
//  - Measures the gap between successive tag backscatter edges and classifies it as N half-bit periods.
//  - Locks after a programmable run of clean pulses, then tracks tag clock drift with a clamped width correction.
//  - Pushes N half-bit line-level symbols per edge into an output FIFO with a valid/ready handshake.
//  - Sits between the edge detector (rise/fall/gap count) and the FM0/Miller bit decoder.

---
 rtl/pulse_sync_pkg.sv | 14 +
 rtl/pulse_sync_divider.sv | 62 ++++++
 rtl/pulse_sync_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pulse_sync_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared types for the RFID Rx pulse-width synchroniser.
package pulse_sync_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_EMIT   = 3'd4
  } state_t;

  localparam int CORR_THR_DEF = 4;

endpackage

// File: rtl/pulse_sync_divider.sv
// Sequential restoring divider: one quotient bit per cycle, GAP_W cycles per divide.
// done_o marks the final iteration; quot_o/rem_o are valid from the next cycle.
module pulse_sync_divider #(
  parameter int GAP_W = 16,
  parameter int PW_W  = 9
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [GAP_W-1:0] dividend_i,
  input  logic [PW_W-1:0]  divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [GAP_W-1:0] quot_o,
  output logic [PW_W-1:0]  rem_o
);
  localparam int CW = $clog2(GAP_W);
  localparam logic [CW-1:0] LAST = CW'(GAP_W - 1);

  logic [GAP_W-1:0] quot_reg;
  logic [PW_W-1:0]  rem_reg;
  logic [PW_W-1:0]  div_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic [PW_W:0]    rem_sh;
  logic [PW_W-1:0]  rem_sub;
  logic             take;

  // Remainder always stays below the divisor, so PW_W bits hold it after each step.
  always_comb begin
    rem_sh  = {rem_reg, quot_reg[GAP_W-1]};
    take    = rem_sh >= {1'b0, div_reg};
    rem_sub = rem_sh[PW_W-1:0] - div_reg;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      quot_reg <= '0;
      rem_reg  <= '0;
      div_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start_i) begin
      quot_reg <= dividend_i;
      rem_reg  <= '0;
      div_reg  <= divisor_i;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      quot_reg <= {quot_reg[GAP_W-2:0], take};
      rem_reg  <= take ? rem_sub : rem_sh[PW_W-1:0];
      cnt_reg  <= cnt_reg + CW'(1);
      if (cnt_reg == LAST) busy_reg <= 1'b0;
    end
  end

  assign busy_o = busy_reg;
  assign done_o = busy_reg && (cnt_reg == LAST);
  assign quot_o = quot_reg;
  assign rem_o  = rem_reg;

endmodule

// File: rtl/pulse_sync_ctrl.sv
// Edge-gap classifier, lock/drift tracker and half-bit symbol FIFO for the RFID Rx path.
module pulse_sync_ctrl
  import pulse_sync_pkg::*;
#(
  parameter int GAP_W      = 16,
  parameter int PW_W       = 9,
  parameter int LOCK_W     = 3,
  parameter int N_MAX      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CORR_THR   = CORR_THR_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [PW_W-1:0]   set_rate_i,
  input  logic [LOCK_W-1:0] set_lock_num_i,
  input  logic              set_lock_double_i,
  input  logic              sync_clr_i,
  input  logic              rise_valid_i,
  input  logic              fall_valid_i,
  input  logic [GAP_W-1:0]  gap_point_i,
  output logic              pulse_sync_o,
  output logic [PW_W-1:0]   pulse_width_o,
  output logic              err_lost_sync_o,
  output logic              err_overrun_o,
  output logic              err_overflow_o,
  output logic              sym_valid_o,
  output logic              sym_data_o,
  input  logic              sym_ready_i
);
  localparam int EW = $clog2(N_MAX + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = PW_W + 1;

  state_t state_reg, state_next;
  logic [PW_W-1:0]   pw_reg;
  logic [NW-1:0]     pw_min_reg, pw_max_reg;
  logic              lock_reg, first_reg, lost_once_reg, cur_edge_reg, last_edge_reg, zero_div_reg;
  logic [LOCK_W-1:0] lock_cnt_reg;
  logic [GAP_W-1:0]  carry_reg, gap_reg, gap_sum_reg;
  logic [EW-1:0]     emit_cnt_reg;
  logic              err_lost_reg, err_overrun_reg, err_overflow_reg;
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_DEPTH-1:0] mem_bits;

  logic             strobe, div_start, div_busy, div_done;
  logic [GAP_W-1:0] div_q, gap_sat, pw_ext, gap_diff;
  logic [PW_W-1:0]  div_r;
  logic [GAP_W:0]   gap_sum;
  logic [NW-1:0]    half, upper, r_ext, n, rate_ext;
  logic             round_up, gap_valid, lock_qual, gap_above, corr_big, pw_up_ok, pw_dn_ok;
  logic             fifo_full, fifo_empty, push, pop, push_ok;

  assign strobe    = rise_valid_i | fall_valid_i;
  assign gap_sum   = {1'b0, gap_point_i} + {1'b0, carry_reg};
  assign gap_sat   = gap_sum[GAP_W] ? '1 : gap_sum[GAP_W-1:0];
  assign div_start = (state_reg == ST_IDLE) && strobe && (pw_reg != '0) && !sync_clr_i;
  assign rate_ext  = {1'b0, set_rate_i};

  pulse_sync_divider #(.GAP_W(GAP_W), .PW_W(PW_W)) u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (div_start),
    .dividend_i (gap_sat),
    .divisor_i  (pw_reg),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_q),
    .rem_o      (div_r)
  );

  // A remainder in the dead band around half a period is ambiguous and rejected.
  always_comb begin
    half      = {1'b0, pw_reg >> 1};
    upper     = {1'b0, pw_reg} - half;
    r_ext     = {1'b0, div_r};
    round_up  = r_ext > upper;
    n         = div_q[NW-1:0] + {{PW_W{1'b0}}, round_up};
    gap_valid = !zero_div_reg && (div_q <= GAP_W'(N_MAX)) && (n != '0) && (n <= NW'(N_MAX))
                && ((r_ext < half) || round_up)
                && !((n == NW'(1)) && (cur_edge_reg == last_edge_reg));
    lock_qual = gap_valid && (n == (set_lock_double_i ? NW'(2) : NW'(1)));
    pw_ext    = GAP_W'(pw_reg);
    gap_above = gap_sum_reg > pw_ext;
    gap_diff  = gap_above ? (gap_sum_reg - pw_ext) : (pw_ext - gap_sum_reg);
    corr_big  = gap_diff > GAP_W'(CORR_THR);
    pw_up_ok  = ({1'b0, pw_reg} < pw_max_reg) && (pw_reg != {PW_W{1'b1}});
    pw_dn_ok  = {1'b0, pw_reg} > pw_min_reg;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= ST_RESET;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET:  state_next = ST_IDLE;
      ST_IDLE:   if (strobe) state_next = (pw_reg == '0) ? ST_CHECK : ST_DIVIDE;
      ST_DIVIDE: if (div_done || !div_busy) state_next = ST_CHECK;
      ST_CHECK:  state_next = (lock_reg && gap_valid) ? ST_EMIT : ST_IDLE;
      ST_EMIT:   if (emit_cnt_reg <= EW'(1)) state_next = ST_IDLE;
      default:   state_next = ST_RESET;
    endcase
    if (sync_clr_i) state_next = ST_RESET;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pw_reg <= '0;  pw_min_reg <= '0;  pw_max_reg <= '0;
      lock_reg <= 1'b0;  first_reg <= 1'b0;  lost_once_reg <= 1'b0;
      cur_edge_reg <= 1'b0;  last_edge_reg <= 1'b0;  zero_div_reg <= 1'b0;
      lock_cnt_reg <= '0;  carry_reg <= '0;  gap_reg <= '0;  gap_sum_reg <= '0;
      emit_cnt_reg <= '0;  err_lost_reg <= 1'b0;  err_overrun_reg <= 1'b0;
    end else if (sync_clr_i) begin
      lock_reg        <= 1'b0;
      err_lost_reg    <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      if (strobe && (state_reg != ST_IDLE)) err_overrun_reg <= 1'b1;
      case (state_reg)
        ST_RESET: begin
          pw_reg <= set_rate_i;
          pw_min_reg <= rate_ext - (rate_ext >> 2);
          pw_max_reg <= rate_ext + (rate_ext >> 2);
          lock_reg <= 1'b0;  lock_cnt_reg <= '0;  carry_reg <= '0;
          lost_once_reg <= 1'b0;  first_reg <= 1'b1;  last_edge_reg <= 1'b0;
        end
        ST_IDLE: if (strobe) begin
          gap_reg      <= gap_point_i;
          gap_sum_reg  <= gap_sat;
          cur_edge_reg <= rise_valid_i;
          zero_div_reg <= (pw_reg == '0);
        end
        ST_CHECK: begin
          emit_cnt_reg <= n[EW-1:0];
          if (gap_valid || first_reg) begin
            carry_reg <= '0;  last_edge_reg <= cur_edge_reg;
            lost_once_reg <= 1'b0;  first_reg <= 1'b0;
          end else begin
            carry_reg <= gap_reg;
            if (lock_reg && lost_once_reg) begin
              err_lost_reg <= 1'b1;  lock_reg <= 1'b0;
              lock_cnt_reg <= '0;  pw_reg <= set_rate_i;
            end else if (lock_reg) begin
              lost_once_reg <= 1'b1;
            end
          end
          if (!lock_reg) begin
            if (!first_reg) begin
              if (!lock_qual)                          lock_cnt_reg <= '0;
              else if (lock_cnt_reg < set_lock_num_i)  lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
              else                                     lock_reg <= 1'b1;
            end
          end else if (gap_valid && (n == NW'(1)) && corr_big) begin
            if (gap_above && pw_up_ok)       pw_reg <= pw_reg + PW_W'(1);
            else if (!gap_above && pw_dn_ok) pw_reg <= pw_reg - PW_W'(1);
          end
        end
        ST_EMIT: emit_cnt_reg <= emit_cnt_reg - EW'(1);
        default: ;
      endcase
    end
  end

  // Extra pointer bit separates full from empty; a pop frees room for a same-cycle push.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && sym_ready_i;
  assign push       = (state_reg == ST_EMIT) && !sync_clr_i;
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;  rd_ptr_reg <= '0;  err_overflow_reg <= 1'b0;
    end else if (sync_clr_i) begin
      wr_ptr_reg <= '0;  rd_ptr_reg <= '0;  err_overflow_reg <= 1'b0;
    end else begin
      if (push_ok)         wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)             rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (push && !push_ok) err_overflow_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
    logic cell_reg;
    always_ff @(posedge clk_i) begin
      if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi))) cell_reg <= ~cur_edge_reg;
    end
    assign mem_bits[gi] = cell_reg;
  end

  assign pulse_sync_o    = lock_reg;
  assign pulse_width_o   = pw_reg;
  assign err_lost_sync_o = err_lost_reg;
  assign err_overrun_o   = err_overrun_reg;
  assign err_overflow_o  = err_overflow_reg;
  assign sym_valid_o     = !fifo_empty;
  assign sym_data_o      = !fifo_empty && mem_bits[rd_ptr_reg[AW-1:0]];

endmodule

// File: tb/tb_pulse_sync_ctrl.sv
// Directed bench for pulse_sync_ctrl: edge table plus overrun, overflow, latency and reset sequences.
module tb_pulse_sync_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  set_rate = 9'd40;
  logic [2:0]  set_lock_num = 3'd3;
  logic        set_lock_double = 1'b0;
  logic        sync_clr = 1'b0;
  logic        rise_valid = 1'b0;
  logic        fall_valid = 1'b0;
  logic [15:0] gap_point = '0;
  logic        sym_ready = 1'b0;
  logic        pulse_sync, err_lost, err_overrun, err_overflow, sym_valid, sym_data;
  logic [8:0]  pulse_width;
  logic [14:0] outs;

  always #5 clk = ~clk;

  pulse_sync_ctrl dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .set_rate_i        (set_rate),
    .set_lock_num_i    (set_lock_num),
    .set_lock_double_i (set_lock_double),
    .sync_clr_i        (sync_clr),
    .rise_valid_i      (rise_valid),
    .fall_valid_i      (fall_valid),
    .gap_point_i       (gap_point),
    .pulse_sync_o      (pulse_sync),
    .pulse_width_o     (pulse_width),
    .err_lost_sync_o   (err_lost),
    .err_overrun_o     (err_overrun),
    .err_overflow_o    (err_overflow),
    .sym_valid_o       (sym_valid),
    .sym_data_o        (sym_data),
    .sym_ready_i       (sym_ready)
  );

  assign outs = {pulse_sync, pulse_width, err_lost, err_overrun, err_overflow, sym_valid, sym_data};

  typedef struct {
    bit clr;
    bit rise;
    int gap;
    bit exp_lock;
    int exp_pw;
    int exp_nsym;
    bit exp_lost;
  } vec_t;

  vec_t vecs[$];
  bit   got_q[$];
  bit   next_rise = 1'b1;
  int   checks = 0;
  int   errors = 0;

  function automatic void add_vec(bit clr, int gap, bit lk, int pw, int nsym, bit lost);
    vec_t v;
    v.clr = clr;  v.rise = next_rise;  v.gap = gap;
    v.exp_lock = lk;  v.exp_pw = pw;  v.exp_nsym = nsym;  v.exp_lost = lost;
    vecs.push_back(v);
    next_rise = !next_rise;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_edge(bit rise, int gap);
    @(negedge clk);
    rise_valid = rise;
    fall_valid = !rise;
    gap_point  = gap[15:0];
    @(negedge clk);
    rise_valid = 1'b0;
    fall_valid = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic drain();
    got_q.delete();
    sym_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!sym_valid) break;
      got_q.push_back(sym_data);
      sym_ready = 1'b1;
      @(negedge clk);
      sym_ready = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Lock: first edge only arms, three clean pulses count, the fifth edge locks.
    add_vec(0, 40, 0, 40, 0, 0);
    add_vec(0, 40, 0, 40, 0, 0);
    add_vec(0, 40, 0, 40, 0, 0);
    add_vec(0, 40, 0, 40, 0, 0);
    add_vec(0, 40, 1, 40, 0, 0);
    add_vec(0, 40, 1, 40, 1, 0);
    add_vec(0, 40, 1, 40, 1, 0);
    // Multi-period gap, then two invalid gaps (carry 140 + 1000 is still out of range).
    add_vec(0, 120, 1, 40, 3, 0);
    add_vec(0, 140, 1, 40, 0, 0);
    add_vec(0, 1000, 0, 40, 0, 1);
    // Clear, relock, then drift tracking and clamp at 40 + 40/4.
    add_vec(1, 40, 0, 40, 0, 0);
    add_vec(0, 40, 0, 40, 0, 0);
    add_vec(0, 40, 0, 40, 0, 0);
    add_vec(0, 40, 0, 40, 0, 0);
    add_vec(0, 40, 1, 40, 0, 0);
    add_vec(0, 46, 1, 41, 1, 0);
    add_vec(0, 46, 1, 42, 1, 0);
    add_vec(0, 46, 1, 42, 1, 0);
    for (int p = 43; p <= 50; p++) add_vec(0, 60, 1, p, 1, 0);
    add_vec(0, 60, 1, 50, 1, 0);

    repeat (3) @(negedge clk);
    check("reset_outs", int'(outs), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pw", int'(pulse_width), 40);
    check("reset_valid", int'(sym_valid), 0);

    foreach (vecs[i]) begin
      if (vecs[i].clr) begin
        do_clr();
        check($sformatf("v%0d_clr_lost", i), int'(err_lost), 0);
      end
      apply_edge(vecs[i].rise, vecs[i].gap);
      drain();
      $display("edge %0d %s gap=%0d lock=%0d pw=%0d syms=%0d lost=%0d", i,
               vecs[i].rise ? "rise" : "fall", vecs[i].gap, pulse_sync, pulse_width,
               got_q.size(), err_lost);
      check($sformatf("v%0d_nsym", i), got_q.size(), vecs[i].exp_nsym);
      foreach (got_q[k]) check($sformatf("v%0d_level%0d", i, k), int'(got_q[k]), int'(!vecs[i].rise));
      check($sformatf("v%0d_lock", i), int'(pulse_sync), int'(vecs[i].exp_lock));
      check($sformatf("v%0d_pw", i), int'(pulse_width), vecs[i].exp_pw);
      check($sformatf("v%0d_lost", i), int'(err_lost), int'(vecs[i].exp_lost));
    end
    check("ovr_before", int'(err_overrun), 0);
    check("ovf_before", int'(err_overflow), 0);

    // Overrun: a second strobe while the first is being divided is ignored.
    @(negedge clk);
    fall_valid = 1'b1;  gap_point = 16'd50;
    @(negedge clk);
    fall_valid = 1'b0;  rise_valid = 1'b1;
    @(negedge clk);
    rise_valid = 1'b0;
    repeat (30) @(negedge clk);
    drain();
    $display("overrun: syms=%0d err_overrun=%0d", got_q.size(), err_overrun);
    check("ovr_flag", int'(err_overrun), 1);
    check("ovr_nsym", got_q.size(), 1);
    if (got_q.size() > 0) check("ovr_level", int'(got_q[0]), 1);

    // Overflow: consumer stalled, 17 single-period edges into a 16-deep FIFO.
    for (int e = 0; e < 17; e++) begin
      apply_edge(e % 2 == 0, 50);
      $display("fill %0d: valid=%0d overflow=%0d", e, sym_valid, err_overflow);
      if (e == 15) check("ovf_at16", int'(err_overflow), 0);
    end
    check("ovf_flag", int'(err_overflow), 1);
    drain();
    $display("drain: syms=%0d", got_q.size());
    check("ovf_drain_n", got_q.size(), 16);
    foreach (got_q[k]) check($sformatf("ovf_level%0d", k), int'(got_q[k]), k % 2);

    // Latency to first symbol, then async reset in the middle of an 8-symbol EMIT.
    @(negedge clk);
    fall_valid = 1'b1;  gap_point = 16'd400;
    @(negedge clk);
    fall_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("lat_before", int'(sym_valid), 0);
    @(negedge clk);
    check("lat_first", int'(sym_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset mid-emit: outs=%0h", outs);
    check("rst_outs", int'(outs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("after reset: pw=%0d valid=%0d lock=%0d", pulse_width, sym_valid, pulse_sync);
    check("rst_valid", int'(sym_valid), 0);
    check("rst_pw", int'(pulse_width), 40);
    check("rst_lock", int'(pulse_sync), 0);
    check("rst_ovf", int'(err_overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
